// File: rtl/char_pixel_renderer_pkg.sv
`default_nettype none
// ============================================================================
// char_pixel_renderer_pkg : OSD renderer state encodings, default geometry and
//                           the glyph table shared by the renderer and font ROM
// Revision: 1.0
// ============================================================================
package char_pixel_renderer_pkg;

  localparam int C_FONT_WIDTH        = 5;
  localparam int C_FONT_HEIGHT       = 8;
  localparam int C_CHAR_IMAGE_WIDTH  = 80;
  localparam int C_CHAR_IMAGE_HEIGHT = 34;
  localparam int C_PIXEL_WIDTH       = 24;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Glyph bitmap rows, MSB = leftmost pixel. Code 0x00 is the blank glyph.
  function automatic logic [31:0] glyph_row(input logic [7:0] ch, input logic [7:0] row);
    logic [31:0] h;
    if (ch == 8'h00) begin
      h = '0;
    end else begin
      h = (32'(ch) * 32'd37) ^ (32'(row) * 32'd11) ^ (32'(ch) >> row[1:0]);
    end
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/char_pixel_renderer_font_rom.sv
`default_nettype none
// ============================================================================
// font_rom : synchronous glyph ROM, address {char[7:0], row}, one-cycle latency
// Revision: 1.0
// ============================================================================
module font_rom
  import char_pixel_renderer_pkg::*;
#(
  parameter int FONT_WIDTH  = C_FONT_WIDTH,
  parameter int FONT_HEIGHT = C_FONT_HEIGHT,
  localparam int ROW_W      = idx_bits(FONT_HEIGHT)
) (
  input  logic                  clk,
  input  logic [ROW_W+7:0]      addr_i,
  output logic [FONT_WIDTH-1:0] data_o
);

  logic [FONT_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    data_q <= FONT_WIDTH'(glyph_row(addr_i[ROW_W+7:ROW_W], 8'(addr_i[ROW_W-1:0])));
  end

  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/char_pixel_renderer.sv
`default_nettype none
// ============================================================================
// char_pixel_renderer : turns a character stream into a raster of coloured
//                       pixels through a glyph ROM, with valid/ready output
// Revision: 1.0
// ============================================================================
module char_pixel_renderer
  import char_pixel_renderer_pkg::*;
#(
  parameter int FONT_WIDTH        = C_FONT_WIDTH,
  parameter int FONT_HEIGHT       = C_FONT_HEIGHT,
  parameter int CHAR_IMAGE_WIDTH  = C_CHAR_IMAGE_WIDTH,
  parameter int CHAR_IMAGE_HEIGHT = C_CHAR_IMAGE_HEIGHT,
  parameter int PIXEL_WIDTH       = C_PIXEL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_frame_start_stb,
  output logic                   o_read_frame_stb,
  output logic                   o_char_req_en,
  input  logic                   i_char_rdy,
  input  logic [7:0]             i_char,
  input  logic [PIXEL_WIDTH-1:0] i_fg_color,
  input  logic [PIXEL_WIDTH-1:0] i_bg_color,
  output logic [PIXEL_WIDTH-1:0] o_pixel_data,
  output logic                   o_pixel_valid,
  input  logic                   i_pixel_ready,
  output logic                   o_pixel_sof,
  output logic                   o_pixel_eol,
  output logic                   o_busy
);

  localparam int COL_W  = idx_bits(CHAR_IMAGE_WIDTH);
  localparam int ROW_W  = idx_bits(FONT_HEIGHT);
  localparam int LINE_W = idx_bits(CHAR_IMAGE_HEIGHT);
  localparam int CNT_W  = $clog2(FONT_WIDTH + 1);

  state_e              state_q;
  logic                read_stb_q;

  logic [COL_W-1:0]    char_col_q;
  logic [ROW_W-1:0]    font_row_q;
  logic [LINE_W-1:0]   char_line_q;

  logic [7:0]          fifo_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          fifo_cnt_q;

  logic                rom_vld_q, rom_sof_q, rom_eol_q, rom_eof_q;
  logic                nxt_vld_q, nxt_sof_q, nxt_eol_q, nxt_eof_q;
  logic [FONT_WIDTH-1:0] nxt_row_q;
  logic [FONT_WIDTH-1:0] sh_q;
  logic [CNT_W-1:0]    sh_cnt_q;
  logic                sh_sof_q, sh_eol_q, sh_eof_q;

  logic                pix_valid_q, pix_sof_q, pix_eol_q, pix_eof_q;
  logic [PIXEL_WIDTH-1:0] pix_data_q;

  logic                last_col, last_row, last_line, last_char, frame_first;
  logic                push, pop, out_ld, sh_take, pix_accept;
  logic [ROW_W+7:0]    rom_addr;
  logic [FONT_WIDTH-1:0] rom_data;

  assign last_col    = (char_col_q == COL_W'(CHAR_IMAGE_WIDTH - 1));
  assign last_row    = (font_row_q == ROW_W'(FONT_HEIGHT - 1));
  assign last_line   = (char_line_q == LINE_W'(CHAR_IMAGE_HEIGHT - 1));
  assign last_char   = last_col && last_row && last_line;
  assign frame_first = (char_col_q == '0) && (font_row_q == '0) && (char_line_q == '0);

  // Only one glyph row may be in flight between the FIFO and the shifter,
  // so a pop waits for both the ROM stage and the prefetch slot to be free.
  assign pop  = (state_q == S_RUN) && (fifo_cnt_q != 2'd0) && !nxt_vld_q && !rom_vld_q;
  assign push = i_char_rdy && ((fifo_cnt_q != 2'd2) || pop);

  assign out_ld     = (sh_cnt_q != '0) && (!pix_valid_q || i_pixel_ready);
  assign sh_take    = nxt_vld_q && ((sh_cnt_q == '0) || (out_ld && (sh_cnt_q == CNT_W'(1))));
  assign pix_accept = pix_valid_q && i_pixel_ready;

  assign rom_addr = {fifo_q[rd_ptr_q], font_row_q};

  font_rom #(
    .FONT_WIDTH  (FONT_WIDTH),
    .FONT_HEIGHT (FONT_HEIGHT)
  ) u_font_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      read_stb_q <= 1'b0;
    end else begin
      read_stb_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_frame_start_stb) begin
            state_q    <= S_START;
            read_stb_q <= 1'b1;
          end
        end
        S_START: state_q <= S_RUN;
        S_RUN:   if (pop && last_char) state_q <= S_DRAIN;
        S_DRAIN: if (pix_accept && pix_eof_q) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_col_q  <= '0;
      font_row_q  <= '0;
      char_line_q <= '0;
    end else if (state_q == S_START) begin
      char_col_q  <= '0;
      font_row_q  <= '0;
      char_line_q <= '0;
    end else if (pop) begin
      if (last_col) begin
        char_col_q <= '0;
        if (last_row) begin
          font_row_q  <= '0;
          char_line_q <= last_line ? '0 : char_line_q + LINE_W'(1);
        end else begin
          font_row_q <= font_row_q + ROW_W'(1);
        end
      end else begin
        char_col_q <= char_col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= i_char;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // ROM result lands in the prefetch slot so the next glyph row is ready
  // before the shifter runs out of pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_vld_q <= 1'b0;
      rom_sof_q <= 1'b0;
      rom_eol_q <= 1'b0;
      rom_eof_q <= 1'b0;
      nxt_vld_q <= 1'b0;
      nxt_row_q <= '0;
      nxt_sof_q <= 1'b0;
      nxt_eol_q <= 1'b0;
      nxt_eof_q <= 1'b0;
      sh_q      <= '0;
      sh_cnt_q  <= '0;
      sh_sof_q  <= 1'b0;
      sh_eol_q  <= 1'b0;
      sh_eof_q  <= 1'b0;
    end else begin
      rom_vld_q <= pop;
      if (pop) begin
        rom_sof_q <= frame_first;
        rom_eol_q <= last_col;
        rom_eof_q <= last_char;
      end

      if (rom_vld_q) begin
        nxt_vld_q <= 1'b1;
        nxt_row_q <= rom_data;
        nxt_sof_q <= rom_sof_q;
        nxt_eol_q <= rom_eol_q;
        nxt_eof_q <= rom_eof_q;
      end else if (sh_take) begin
        nxt_vld_q <= 1'b0;
      end

      if (sh_take) begin
        sh_q     <= nxt_row_q;
        sh_cnt_q <= CNT_W'(FONT_WIDTH);
        sh_sof_q <= nxt_sof_q;
        sh_eol_q <= nxt_eol_q;
        sh_eof_q <= nxt_eof_q;
      end else if (out_ld) begin
        sh_q     <= sh_q << 1;
        sh_cnt_q <= sh_cnt_q - CNT_W'(1);
        sh_sof_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      pix_eof_q   <= 1'b0;
    end else if (out_ld) begin
      pix_valid_q <= 1'b1;
      pix_data_q  <= sh_q[FONT_WIDTH-1] ? i_fg_color : i_bg_color;
      pix_sof_q   <= sh_sof_q;
      pix_eol_q   <= sh_eol_q && (sh_cnt_q == CNT_W'(1));
      pix_eof_q   <= sh_eof_q && (sh_cnt_q == CNT_W'(1));
    end else if (i_pixel_ready) begin
      pix_valid_q <= 1'b0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      pix_eof_q   <= 1'b0;
    end
  end

  assign o_read_frame_stb = read_stb_q;
  assign o_char_req_en    = (state_q == S_RUN) && (fifo_cnt_q == 2'd0);
  assign o_busy           = (state_q != S_IDLE);
  assign o_pixel_data     = pix_data_q;
  assign o_pixel_valid    = pix_valid_q;
  assign o_pixel_sof      = pix_sof_q;
  assign o_pixel_eol      = pix_eol_q;

endmodule
`default_nettype wire

// File: tb/tb_char_pixel_renderer.sv
`default_nettype none
// ============================================================================
// tb_char_pixel_renderer : scoreboard bench for char_pixel_renderer on a small
//                          4x2 character raster
// Revision: 1.0
// ============================================================================
module tb_char_pixel_renderer;
  import char_pixel_renderer_pkg::*;

  localparam int FW      = 5;
  localparam int FH      = 8;
  localparam int CW      = 4;
  localparam int CH      = 2;
  localparam int PW      = 24;
  localparam int TOTAL   = CW * FH * CH;
  localparam int COLS_PX = CW * FW;
  localparam int ROWS    = FH * CH;

  typedef struct packed {
    logic [PW-1:0] data;
    logic          sof;
    logic          eol;
    logic          first;
    logic          last;
  } exp_t;

  logic          clk, rst;
  logic          i_frame_start_stb, o_read_frame_stb, o_char_req_en;
  logic          i_char_rdy;
  logic [7:0]    i_char;
  logic [PW-1:0] i_fg_color, i_bg_color, o_pixel_data;
  logic          o_pixel_valid, i_pixel_ready, o_pixel_sof, o_pixel_eol, o_busy;

  char_pixel_renderer #(
    .FONT_WIDTH        (FW),
    .FONT_HEIGHT       (FH),
    .CHAR_IMAGE_WIDTH  (CW),
    .CHAR_IMAGE_HEIGHT (CH),
    .PIXEL_WIDTH       (PW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_frame_start_stb (i_frame_start_stb),
    .o_read_frame_stb  (o_read_frame_stb),
    .o_char_req_en     (o_char_req_en),
    .i_char_rdy        (i_char_rdy),
    .i_char            (i_char),
    .i_fg_color        (i_fg_color),
    .i_bg_color        (i_bg_color),
    .o_pixel_data      (o_pixel_data),
    .o_pixel_valid     (o_pixel_valid),
    .i_pixel_ready     (i_pixel_ready),
    .o_pixel_sof       (o_pixel_sof),
    .o_pixel_eol       (o_pixel_eol),
    .o_busy            (o_busy)
  );

  int   total_cnt = 0;
  int   bad_cnt   = 0;
  exp_t exp_q[$];
  logic [7:0] chars [TOTAL];

  int stb_cnt = 0, sent_cnt = 0, sof_seen = 0, eol_seen = 0, acc_cnt = 0, nz_cnt = 0;
  int stb0, sent0, sof0, eol0;
  int frame_kind = 0;
  bit ready_rand = 0;
  bit strict_gap = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total_cnt++;
    if (act !== want) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Character buffer: answers a request one cycle later, stops at the frame size.
  initial begin : char_buffer
    int ch_left, ch_idx;
    bit req_prev;
    ch_left = 0; ch_idx = 0; req_prev = 0;
    i_char_rdy = 1'b0;
    i_char     = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ch_left = 0; req_prev = 0; i_char_rdy = 1'b0;
      end else begin
        if (o_read_frame_stb) begin
          ch_left = TOTAL; ch_idx = 0; stb_cnt++;
        end
        if (req_prev && ch_left > 0) begin
          i_char_rdy = 1'b1;
          i_char     = chars[ch_idx];
          ch_idx++; ch_left--; sent_cnt++;
        end else begin
          i_char_rdy = 1'b0;
        end
        req_prev = o_char_req_en;
      end
    end
  end

  initial begin : ready_driver
    i_pixel_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      i_pixel_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    int   cyc, prev_cyc;
    bit   hold, busy_chk;
    logic [PW+2:0] held;
    exp_t e;
    cyc = 0; prev_cyc = 0; hold = 0; busy_chk = 0; held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        hold = 0; busy_chk = 0;
      end else begin
        if (busy_chk) begin
          chk("busy_fall", o_busy, 0);
          busy_chk = 0;
        end
        if (hold) chk("stall_hold", {o_pixel_data, o_pixel_sof, o_pixel_eol, o_pixel_valid}, held);
        hold = o_pixel_valid && !i_pixel_ready;
        held = {o_pixel_data, o_pixel_sof, o_pixel_eol, o_pixel_valid};
        if (o_pixel_valid && i_pixel_ready) begin
          acc_cnt++;
          if (o_pixel_sof) sof_seen++;
          if (o_pixel_eol) eol_seen++;
          if (frame_kind == 1 && o_pixel_data != '0) nz_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_pixel", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", {o_pixel_data, o_pixel_sof, o_pixel_eol}, {e.data, e.sof, e.eol});
            if (strict_gap && !e.first) chk("pixel_gap", 64'(cyc - prev_cyc), 1);
            if (e.last) begin
              chk("busy_at_last", o_busy, 1);
              busy_chk = 1;
            end
          end
          prev_cyc = cyc;
        end
      end
    end
  end

  // Reference: pixel (x,y) comes from character ((y/FH)*FH + y%FH)*CW + x/FW.
  task automatic setup_frame(input int kind, input bit rnd);
    logic [PW-1:0] fg, bg;
    logic [31:0]   g;
    exp_t          e;
    for (int i = 0; i < TOTAL; i++)
      chars[i] = (kind == 0) ? 8'h41 : (kind == 1) ? 8'h00 : 8'($urandom_range(0, 255));
    if (kind == 1) begin
      fg = 24'hFFFFFF; bg = 24'h000000;
    end else begin
      fg = 24'($urandom); bg = 24'($urandom);
    end
    i_fg_color = fg;
    i_bg_color = bg;
    frame_kind = kind;
    ready_rand = rnd;
    strict_gap = !rnd;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS_PX; x++) begin
        g       = glyph_row(chars[((y / FH) * FH + (y % FH)) * CW + x / FW], 8'(y % FH));
        e.data  = g[FW - 1 - (x % FW)] ? fg : bg;
        e.sof   = (x == 0 && y == 0);
        e.eol   = (x == COLS_PX - 1);
        e.first = (x == 0);
        e.last  = (x == COLS_PX - 1 && y == ROWS - 1);
        exp_q.push_back(e);
      end
    end
    stb0 = stb_cnt; sent0 = sent_cnt; sof0 = sof_seen; eol0 = eol_seen; nz_cnt = 0;
    @(posedge clk); #1;
    i_frame_start_stb = 1'b1;
    @(posedge clk); #1;
    i_frame_start_stb = 1'b0;
  endtask

  task automatic run_frame(input int kind, input bit rnd, input bit poke);
    bit done;
    setup_frame(kind, rnd);
    done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(posedge clk); #1;
      if (poke) i_frame_start_stb = (i == 40 || i == 300) && o_busy;
      done = (exp_q.size() == 0) && !o_busy;
    end
    i_frame_start_stb = 1'b0;
    chk("frame_done", done, 1);
    chk("read_frame_stb_count", 64'(stb_cnt - stb0), 1);
    chk("chars_consumed", 64'(sent_cnt - sent0), TOTAL);
    chk("sof_count", 64'(sof_seen - sof0), 1);
    chk("eol_count", 64'(eol_seen - eol0), ROWS);
    if (kind == 1) chk("blank_nonzero_pixels", 64'(nz_cnt), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_frame", {o_busy, o_pixel_valid}, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_read_frame_stb"}, o_read_frame_stb, 0);
    chk({tag, "_char_req_en"}, o_char_req_en, 0);
    chk({tag, "_pixel_valid"}, o_pixel_valid, 0);
    chk({tag, "_pixel_sof"}, o_pixel_sof, 0);
    chk({tag, "_pixel_eol"}, o_pixel_eol, 0);
    chk({tag, "_pixel_data"}, o_pixel_data, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin : main
    int start_acc;
    rst = 1'b1;
    i_frame_start_stb = 1'b0;
    i_fg_color = '0;
    i_bg_color = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_frame(0, 1'b0, 1'b0);
    run_frame(1, 1'b1, 1'b0);
    run_frame(2, 1'b1, 1'b0);
    run_frame(2, 1'b0, 1'b1);

    setup_frame(2, 1'b0);
    start_acc = acc_cnt;
    for (int i = 0; i < 5000 && acc_cnt < start_acc + 100; i++) @(posedge clk);
    chk("midframe_progress", 64'(acc_cnt >= start_acc + 100), 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_frame(2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
